panel_fill_master: RTL and testbench
====================================

PANEL_FILL_MASTER -- requirements
Module: panel_fill_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000: LED panel write region base.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles one bus write waits for mem_ready.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  fill command offered.
REQ-006 cmd_ready  output  1  engine idle and able to accept a command.
REQ-007 cmd_x0, cmd_y0  input  5 each  top-left pixel of the rectangle.
REQ-008 cmd_w, cmd_h  input  6 each  rectangle width and height in pixels.
REQ-009 cmd_rgb  input  24  fill colour {R,G,B}.
REQ-010 mem_valid  output  1  bus write request; PicoRV32 native memory protocol, initiator side.
REQ-011 mem_ready  input  1  responder completion, one-cycle pulse.
REQ-012 mem_addr  output  32  byte address of the write.
REQ-013 mem_wdata  output  32  write data.
REQ-014 mem_wstrb  output  4  byte strobes.
REQ-015 busy  output  1  command in progress.
REQ-016 done  output  1  one-cycle pulse at command end.
REQ-017 err  output  1  one-cycle pulse when the command ends through timeout.

Function
REQ-018 The engine SHALL use three states: IDLE, WRITE and FINISH. cmd_ready = (state==IDLE); busy = !IDLE.
REQ-019 IDLE: on cmd_valid && cmd_ready, latch all cmd_* fields in the same cycle.
  - Effective width/height = min(field, 32).
  - Zero width or height: go to FINISH with no bus transaction.
  - Otherwise go to WRITE with x=y=0 offsets.
REQ-020 WRITE: mem_valid SHALL be 1 in the first cycle after acceptance.
  - Pixel address = BASE_ADDR | ({py,px} << 2), where px = (x0+xoff) mod 32 and py = (y0+yoff) mod 32 (5-bit wrap-around).
REQ-021 During a write: mem_wdata = {8'h00, rgb}, mem_wstrb = 4'hF.
REQ-022 mem_addr, mem_wdata and mem_wstrb SHALL stay stable while mem_valid=1 and mem_ready is not yet sampled high.
REQ-023 Scan order is raster: xoff increments first; at xoff = w-1, xoff returns to 0 and yoff increments.
REQ-024 On the cycle mem_ready=1 is sampled:
  - Not the last pixel: the next pixel is presented in the following cycle, with mem_valid kept 1. Back-to-back operation gives 2 cycles per pixel against a registered-ready responder.
  - Last pixel: mem_valid drops to 0 in the following cycle and the state goes to FINISH.
REQ-025 A wait counter SHALL clear on every new request and increment each cycle mem_valid=1 && mem_ready=0.
  - On reaching TIMEOUT: drop mem_valid, pulse err, go to FINISH; remaining pixels are abandoned.
REQ-026 FINISH SHALL last exactly one cycle: done=1, then IDLE.
  - Minimum latency from acceptance to done: 1 cycle for a zero-size command; 2*w*h+1 cycles for a zero-wait responder.
REQ-027 mem_ready while mem_valid=0 SHALL be ignored.
REQ-028 mem_ready arriving in the same cycle as the timeout threshold SHALL count as success, with no err.
REQ-029 cmd_valid while busy SHALL be ignored; no queueing.
REQ-030 The engine SHALL never issue reads; mem_wstrb = 4'h0 whenever mem_valid=0.

Reset
REQ-031 Reset assertion SHALL force, asynchronously, in any state including mid-write:
  - state IDLE and all counters 0;
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0;
  - busy=0, done=0, err=0.
REQ-032 After reset, cmd_ready SHALL be 1; commands presented while reset is asserted are ignored.
REQ-033 A write interrupted by reset SHALL NOT be reissued after reset release.

Verification
REQ-034 Single pixel: x0=3, y0=2, w=h=1, rgb=24'h12_34_56, responder ready one cycle after valid. Required: one write, mem_addr=32'h1000_0000|(67<<2)=32'h1000_010C, wdata=32'h0012_3456, wstrb=F, done 3 cycles after acceptance.
REQ-035 2x2 fill at x0=31, y0=31. Required address order: {31,31}, {31,0}, {0,31}, {0,0} as {y,x}<<2 (wrap-around); exactly 4 writes; done once.
REQ-036 w=0, h=5. Required: no mem_valid; done one cycle after acceptance; cmd_ready back to 1 the next cycle.
REQ-037 Responder never asserts mem_ready, TIMEOUT=8. Required: mem_valid high 8 cycles then low; err and done pulse together; no further writes.
REQ-038 Reset asserted during the 3rd write of a 4x1 fill. Required: mem_valid=0 immediately; idle outputs; cmd_ready=1 after release; no further writes.
REQ-039 Random responder wait states (0-5 cycles) on a 32x32 fill. Required: 1024 writes, each addr/wdata stable until ready, no duplicate or missing addresses.

Source files
------------

// File: rtl/panel_fill_master_if.sv
// Fill-command port plus PicoRV32-style native write bus of the panel fill engine.
// master = the fill engine, slave = whoever issues commands and answers the bus.
interface panel_fill_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_x0;
   logic [4:0]  cmd_y0;
   logic [5:0]  cmd_w;
   logic [5:0]  cmd_h;
   logic [23:0] cmd_rgb;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   modport master (
      input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_rgb, mem_ready,
      output cmd_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_rgb, mem_ready,
      input  cmd_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/panel_fill_master.sv
// Rectangle fill engine: one word write per pixel in raster order with 5-bit coordinate wrap.
// First write one cycle after acceptance; each write holds until mem_ready or TIMEOUT; no queueing while busy.
module panel_fill_master #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                reset,
   panel_fill_master_if.master bus,
   output logic                busy,
   output logic                done,
   output logic                err
);
   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

   state_t      state, state_nxt;
   logic [4:0]  x0, y0, xoff, yoff;
   logic [5:0]  w, h;
   logic [23:0] rgb;
   logic [31:0] wait_cnt;
   logic        timed_out;

   logic        accept, zero_size, beat_ok, last_col, last_px, timeout_hit;
   logic [5:0]  w_eff, h_eff;
   logic [4:0]  px, py;

   always_comb begin
      w_eff       = (bus.cmd_w > 6'd32) ? 6'd32 : bus.cmd_w;
      h_eff       = (bus.cmd_h > 6'd32) ? 6'd32 : bus.cmd_h;
      zero_size   = (w_eff == 6'd0) || (h_eff == 6'd0);
      accept      = (state == IDLE) && bus.cmd_valid;
      beat_ok     = (state == WRITE) && bus.mem_ready;
      last_col    = ({1'b0, xoff} == w - 6'd1);
      last_px     = last_col && ({1'b0, yoff} == h - 6'd1);
      // a ready arriving on the threshold cycle wins over the timeout
      timeout_hit = (state == WRITE) && !bus.mem_ready && (wait_cnt + 32'd1 >= TIMEOUT);
      px          = x0 + xoff;
      py          = y0 + yoff;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.cmd_ready = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;
      bus.mem_wstrb = 4'h0;
      busy          = (state != IDLE);
      done          = 1'b0;
      err           = 1'b0;
      case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (accept) state_nxt = zero_size ? FINISH : WRITE;
         end
         WRITE: begin
            bus.mem_valid = 1'b1;
            bus.mem_addr  = BASE_ADDR | {20'd0, py, px, 2'b00};
            bus.mem_wdata = {8'h00, rgb};
            bus.mem_wstrb = 4'hF;
            if ((beat_ok && last_px) || timeout_hit) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            err       = timed_out;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0        <= '0;
         y0        <= '0;
         w         <= '0;
         h         <= '0;
         rgb       <= '0;
         xoff      <= '0;
         yoff      <= '0;
         wait_cnt  <= '0;
         timed_out <= 1'b0;
      end else if (accept) begin
         x0        <= bus.cmd_x0;
         y0        <= bus.cmd_y0;
         w         <= w_eff;
         h         <= h_eff;
         rgb       <= bus.cmd_rgb;
         xoff      <= '0;
         yoff      <= '0;
         wait_cnt  <= '0;
         timed_out <= 1'b0;
      end else if (beat_ok) begin
         wait_cnt <= '0;
         if (!last_px) begin
            if (last_col) begin
               xoff <= '0;
               yoff <= yoff + 5'd1;
            end else begin
               xoff <= xoff + 5'd1;
            end
         end
      end else if (timeout_hit) begin
         wait_cnt  <= '0;
         timed_out <= 1'b1;
      end else if (state == WRITE) begin
         wait_cnt <= wait_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_panel_fill_master.sv
// Testbench for panel_fill_master with a short bus timeout.
module tb_panel_fill_master;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int unsigned TMO  = 8;

   logic clk, reset, busy, done, err;
   panel_fill_master_if bus();

   panel_fill_master #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .bus(bus), .busy(busy), .done(done), .err(err)
   );

   int          n_assert = 0, n_fail = 0;
   int          cyc = 0, n_vcyc = 0, n_done = 0;
   logic [31:0] wq[$], dq[$], exp_q[$];
   int          resp_lat = 1;
   bit          resp_rand = 1'b0, stray = 1'b0;
   int          vcnt = 0, cur_lat = 1;
   logic        p_valid = 1'b0, p_ready = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic [3:0]  p_wstrb = '0;

   typedef struct {
      int          x0, y0, w, h;
      logic [23:0] rgb;
      int          exp_writes;
      int          exp_lat;
      logic [31:0] exp_first;
   } vec_t;
   vec_t vecs[8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Expected write addresses: raster over the clamped rectangle, each coordinate mod 32.
   task automatic build_exp(input int x0, input int y0, input int w, input int h);
      int we, he;
      we = (w > 32) ? 32 : w;
      he = (h > 32) ? 32 : h;
      exp_q.delete();
      for (int yo = 0; yo < he; yo++)
         for (int xo = 0; xo < we; xo++)
            exp_q.push_back(BASE | 32'((((y0 + yo) % 32) * 32 + ((x0 + xo) % 32)) * 4));
   endtask

   // Responder: ready comes cur_lat valid cycles after a request appears (1 = zero-wait registered).
   initial begin
      bus.mem_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset || bus.mem_ready || !bus.mem_valid) vcnt = 0;
         if (!reset && bus.mem_valid) begin
            if (vcnt == 0) cur_lat = resp_rand ? 1 + int'($urandom_range(0, 5)) : resp_lat;
            vcnt++;
            bus.mem_ready = (vcnt == cur_lat + 1);
         end else begin
            bus.mem_ready = stray ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
         end else begin
            if (bus.mem_valid) n_vcyc++;
            if (done) n_done++;
            if (bus.mem_valid && bus.mem_ready) begin
               wq.push_back(bus.mem_addr);
               dq.push_back(bus.mem_wdata);
            end
            check("strobe", 64'(bus.mem_wstrb), bus.mem_valid ? 64'hF : 64'h0);
            check("busy_vs_ready", 64'(busy), 64'(!bus.cmd_ready));
            if (p_valid && !p_ready && bus.mem_valid) begin
               check("hold addr", 64'(bus.mem_addr), 64'(p_addr));
               check("hold data", 64'({bus.mem_wdata, bus.mem_wstrb}), 64'({p_wdata, p_wstrb}));
            end
            p_valid = bus.mem_valid;
            p_ready = bus.mem_ready;
            p_addr  = bus.mem_addr;
            p_wdata = bus.mem_wdata;
            p_wstrb = bus.mem_wstrb;
         end
      end
   end

   task automatic run_cmd(input string name, input int x0, input int y0, input int w, input int h,
                          input logic [23:0] rgb, input bit junk, input bit exp_err,
                          input int exp_lat, input int max_w, output int nv);
      int acc, lat, d0, v0, n, bad;
      bit seen, got_err;
      build_exp(x0, y0, w, h);
      wq.delete();
      dq.delete();
      d0 = n_done; v0 = n_vcyc; lat = 0; acc = 0; seen = 1'b0; got_err = 1'b0;
      @(posedge clk); #1;
      check({name, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
      bus.cmd_x0 = x0[4:0]; bus.cmd_y0 = y0[4:0];
      bus.cmd_w = w[5:0]; bus.cmd_h = h[5:0];
      bus.cmd_rgb = rgb; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      if (junk) begin
         bus.cmd_x0 = ~x0[4:0]; bus.cmd_y0 = ~y0[4:0];
         bus.cmd_w = 6'd9; bus.cmd_h = 6'd9; bus.cmd_rgb = ~rgb;
      end else begin
         bus.cmd_valid = 1'b0;
      end
      for (int i = 0; i < 9000 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            lat = cyc - acc + 1;
            got_err = err;
         end
      end
      bus.cmd_valid = 1'b0;
      check({name, " done seen"}, 64'(seen), 64'd1);
      check({name, " err"}, 64'(got_err), 64'(exp_err));
      if (exp_lat >= 0) check({name, " latency"}, 64'(lat), 64'(exp_lat));
      @(negedge clk);
      check({name, " ready after done"}, 64'(bus.cmd_ready), 64'd1);
      repeat (4) @(negedge clk);
      check({name, " done count"}, 64'(n_done - d0), 64'd1);
      n = (exp_q.size() < max_w) ? exp_q.size() : max_w;
      check({name, " writes"}, 64'(wq.size()), 64'(n));
      bad = 0;
      for (int i = 0; i < n && i < wq.size(); i++)
         if (wq[i] !== exp_q[i] || dq[i] !== {8'h00, rgb}) bad++;
      check({name, " addr/data order"}, 64'(bad), 64'd0);
      nv = n_vcyc - v0;
   endtask

   initial begin
      int nv, v0, d0, rx, ry, rw, rh;
      bit seen;
      vecs[0] = '{3,  2,  1,  1,  24'h123456, 1,  3,  32'h1000_010C};
      vecs[1] = '{31, 31, 2,  2,  24'hFF0080, 4,  9,  32'h1000_0FFC};
      vecs[2] = '{0,  0,  0,  5,  24'h111111, 0,  1,  32'h0};
      vecs[3] = '{7,  9,  4,  0,  24'h222222, 0,  1,  32'h0};
      vecs[4] = '{0,  0,  40, 1,  24'h00FF00, 32, 65, 32'h1000_0000};
      vecs[5] = '{10, 4,  3,  2,  24'hC0FFEE, 6,  13, 32'h1000_0228};
      vecs[6] = '{30, 0,  4,  1,  24'h0000FF, 4,  9,  32'h1000_0078};
      vecs[7] = '{0,  31, 1,  33, 24'hABCDEF, 32, 65, 32'h1000_0F80};

      bus.cmd_valid = 1'b0; bus.cmd_x0 = '0; bus.cmd_y0 = '0;
      bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_rgb = '0;
      reset = 1'b0;
      #3 reset = 1'b1;
      #1;
      check("reset mem_valid", 64'(bus.mem_valid), 64'd0);
      check("reset mem_addr", 64'(bus.mem_addr), 64'd0);
      check("reset mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
      check("reset busy/done/err", 64'({busy, done, err}), 64'd0);
      // a command offered during reset must be dropped
      bus.cmd_x0 = 5'd1; bus.cmd_w = 6'd2; bus.cmd_h = 6'd2; bus.cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.cmd_valid = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post-reset cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("post-reset no writes", 64'(n_vcyc), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_cmd($sformatf("vec%0d", i), vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
                 vecs[i].rgb, 1'b0, 1'b0, vecs[i].exp_lat, 9999, nv);
         check($sformatf("vec%0d table writes", i), 64'(wq.size()), 64'(vecs[i].exp_writes));
         if (vecs[i].exp_writes > 0 && wq.size() > 0)
            check($sformatf("vec%0d first addr", i), 64'(wq[0]), 64'(vecs[i].exp_first));
         if (vecs[i].exp_writes == 0)
            check($sformatf("vec%0d no mem_valid", i), 64'(nv), 64'd0);
      end

      resp_lat = 1000;
      run_cmd("timeout", 1, 1, 2, 2, 24'hABCDEF, 1'b0, 1'b1, 9, 0, nv);
      check("timeout valid cycles", 64'(nv), 64'd8);
      resp_lat = 7;
      run_cmd("ready_at_limit", 6, 6, 1, 1, 24'h010203, 1'b0, 1'b0, 9, 9999, nv);
      resp_lat = 8;
      run_cmd("ready_after_limit", 6, 6, 1, 1, 24'h010203, 1'b0, 1'b1, 9, 0, nv);
      check("ready_after_limit valid cycles", 64'(nv), 64'd8);
      resp_lat = 1;
      run_cmd("busy_ignore", 4, 4, 3, 1, 24'h55AA55, 1'b1, 1'b0, 7, 9999, nv);

      // reset while the third pixel of a 4x1 fill is on the bus
      wq.delete();
      dq.delete();
      @(posedge clk); #1;
      bus.cmd_x0 = 5'd0; bus.cmd_y0 = 5'd0; bus.cmd_w = 6'd4; bus.cmd_h = 6'd1;
      bus.cmd_rgb = 24'h777777; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk); #1;
         if (wq.size() == 2 && bus.mem_valid) seen = 1'b1;
      end
      check("rst third write reached", 64'(seen), 64'd1);
      reset = 1'b1;
      #1;
      check("rst mem_valid", 64'(bus.mem_valid), 64'd0);
      check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check("rst mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
      check("rst busy/done/err", 64'({busy, done, err}), 64'd0);
      v0 = n_vcyc;
      d0 = n_done;
      bus.cmd_valid = 1'b1;
      repeat (2) @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1 reset = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check("rst writes", 64'(wq.size()), 64'd2);
      check("rst no reissue", 64'(n_vcyc - v0), 64'd0);
      check("rst no done", 64'(n_done - d0), 64'd0);
      check("rst cmd_ready", 64'(bus.cmd_ready), 64'd1);

      resp_rand = 1'b1;
      stray = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rx = int'($urandom_range(0, 31));
         ry = int'($urandom_range(0, 31));
         rw = int'($urandom_range(0, 9));
         rh = int'($urandom_range(0, 5));
         run_cmd($sformatf("rnd%0d", k), rx, ry, rw, rh, 24'($urandom), 1'b0, 1'b0, -1, 9999, nv);
      end
      rx = int'($urandom_range(0, 31));
      ry = int'($urandom_range(0, 31));
      run_cmd("rnd_full", rx, ry, 32, 32, 24'($urandom), 1'b0, 1'b0, -1, 9999, nv);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got still running, want finished");
      $fatal(1, "watchdog expired");
   end
endmodule
